// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed synchronous RAM.
// Sub-word stores are read-modify-write; loads extract and extend the addressed lane.
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd, StCapture, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_illegal;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3_i)
      3'b000:  req_illegal = 1'b0;
      3'b001:  req_illegal = req_addr_i[0];
      3'b010:  req_illegal = |req_addr_i[1:0];
      3'b100:  req_illegal = req_we_i;
      3'b101:  req_illegal = req_we_i | req_addr_i[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // Halfword accesses are aligned, so the byte shift also selects the halfword lane.
  assign shamt    = {addr_q[1:0], 3'b000};
  assign rd_shift = mem_rdata_i >> shamt;

  always_comb begin
    load_ext = mem_rdata_i;
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  assign lane_mask = (funct3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << shamt;
  assign merged    = (mem_rdata_i & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          err_d    = req_illegal;
          if (req_illegal) begin
            rdata_d = '0;
            state_d = StResp;
          end else if (req_we_i && req_funct3_i == 3'b010) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StCapture;
      StCapture: begin
        // The merged word replaces the store data so WR always writes wdata_q.
        if (we_q) begin
          wdata_d = merged;
          state_d = StWr;
        end else begin
          rdata_d = load_ext;
          state_d = StResp;
        end
      end
      StWr: begin
        rdata_d = '0;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_we_o     = (state_q == StWr);
  assign mem_addr_o   = {2'b00, addr_q[31:2]};
  assign mem_wdata_o  = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all data/address widths fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; active bytes LSB-aligned.
REQ-010 resp_valid  output  1  one-cycle response pulse; no backpressure.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned or illegal request, qualified by resp_valid.
REQ-013 mem_we  output  1  word write strobe to the word-addressed RAM.
REQ-014 mem_addr  output  32  word index = {2'b00, addr_q[31:2]}.
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_rdata  input  32  RAM read data, valid the cycle after a non-write cycle presenting mem_addr.

Function
REQ-017 States: IDLE, RD, CAPTURE, WR, RESP; the state register is the only control state.
REQ-018 Accept on posedge with req_valid && req_ready; latch we, funct3, addr, wdata into *_q.
REQ-019 Error check at accept: funct3 011/110/111, store funct3 above 010, H/HU with addr[0]=1, W with addr[1:0]!=0.
REQ-020 Error path: IDLE->RESP; resp_err=1, resp_rdata=0, mem_we never asserted.
REQ-021 Load: IDLE->RD->CAPTURE->RESP; resp_valid in cycle A+3 (A = accept cycle).
REQ-022 Store word: IDLE->WR->RESP; mem_wdata = wdata_q; mem_we high exactly in A+1; resp_valid in A+2.
REQ-023 Store B/H: IDLE->RD->CAPTURE->WR->RESP; CAPTURE merges the active byte(s) into mem_rdata at offset addr_q[1:0]; mem_we in A+3; resp_valid in A+4.
REQ-024 RD: mem_we=0; mem_addr driven as in REQ-014.
REQ-025 CAPTURE: select byte lane addr_q[1:0] or halfword lane addr_q[1]. Extension: B/H sign-extend, BU/HU zero-extend, W passes through. Result registered into resp_rdata.
REQ-026 WR: mem_we=1 for exactly one cycle; mem_addr unchanged from RD; untouched bytes keep RAM contents.
REQ-027 RESP: resp_valid=1 for one cycle, then IDLE; resp_err=0 on success.
REQ-028 mem_we=0 in every state except WR.
REQ-029 resp_rdata holds its last value while resp_valid=0; stores load 0 into resp_rdata.
REQ-030 req_ready=0 in RESP; the earliest next accept is the IDLE cycle following RESP.
REQ-031 Request inputs are ignored outside the accept cycle; changes mid-operation have no effect.

Reset
REQ-032 rst_n low: state=IDLE, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, all *_q=0, req_ready=1. Takes effect immediately, independent of clk.
REQ-033 Reset mid-operation discards the in-flight request: no response, no further memory write. A WR cut by reset may leave the RAM word either old or new.
REQ-034 After rst_n rises, first accept possible on the next posedge.

Verification
REQ-035 RAM word 0x40 = 0x8077F0AB. LB 0x100 -> 0xFFFFFFAB; LBU 0x101 -> 0x000000F0; LH 0x102 -> 0xFFFF8077; LHU 0x102 -> 0x00008077; each with resp_valid at A+3, resp_err=0.
REQ-036 Same word, SB 0x103 wdata 0x12345678 -> single mem_we at A+3, mem_addr 0x40, mem_wdata 0x7877F0AB; then LW 0x100 -> 0x7877F0AB.
REQ-037 SW 0x104 wdata 0xDEADBEEF -> mem_we at A+1, mem_addr 0x41, mem_wdata 0xDEADBEEF; resp_valid at A+2, resp_rdata 0.
REQ-038 LW 0x102, SH 0x101, funct3 011 -> each: resp_valid at A+1, resp_err=1, resp_rdata 0, mem_we never high.
REQ-039 SH 0x100, rst_n pulled low during CAPTURE -> mem_we stays 0, no resp_valid, req_ready=1 immediately; RAM word unchanged.
REQ-040 req_valid held high with four back-to-back loads -> accepts spaced 4 cycles apart, exactly four resp_valid pulses, data in order.
